// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the multi-bin Goertzel engine.
package goertzel_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, DRAIN} state_t;

  localparam int N_MAX_DEF     = 64;
  localparam int WIDTH_DEF     = 16;
  localparam int FRAC_BITS_DEF = 14;
  localparam int BIN_NUM_DEF   = 8;

  // Clamp a wide signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int clamp_len(input int n, input int n_max);
    if (n < 2) return 2;
    if (n > n_max) return n_max;
    return n;
  endfunction

endpackage

// File: rtl/goertzel_coef_rf.sv
// Per-bin cos/sin coefficient registers with one write port and full parallel read-out.
module goertzel_coef_rf
  import goertzel_pkg::*;
#(
  parameter int BIN_NUM = BIN_NUM_DEF,
  parameter int CW      = FRAC_BITS_DEF + 2,
  parameter int AW      = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [AW-1:0]               addr,
  input  logic [CW-1:0]               wr_cos,
  input  logic [CW-1:0]               wr_sin,
  output logic [BIN_NUM-1:0][CW-1:0]  cos_all,
  output logic [BIN_NUM-1:0][CW-1:0]  sin_all
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_all <= '0;
      sin_all <= '0;
    end else if (we) begin
      cos_all[addr] <= wr_cos;
      sin_all[addr] <= wr_sin;
    end
  end

endmodule

// File: rtl/goertzel_bank.sv
// BIN_NUM parallel Goertzel resonators fed by a sample stream; results drained one bin per handshake.
module goertzel_bank
  import goertzel_pkg::*;
#(
  parameter int N_MAX     = N_MAX_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int BIN_NUM   = BIN_NUM_DEF,
  parameter int LOG_N     = $clog2(N_MAX) + 1,
  parameter int CW        = FRAC_BITS + 2,
  parameter int ACC_WIDTH = WIDTH + LOG_N + 2,
  parameter int BW        = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1
)(
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_coef_we,
  input  logic [BW-1:0]     i_coef_addr,
  input  logic [CW-1:0]     i_coef_cos,
  input  logic [CW-1:0]     i_coef_sin,
  input  logic              i_start,
  input  logic [LOG_N-1:0]  i_n_len,
  input  logic [WIDTH-1:0]  i_x,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [WIDTH-1:0]  o_y_re,
  output logic [WIDTH-1:0]  o_y_im,
  output logic [BW-1:0]     o_bin,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  // One guard bit above the raw product so the doubled feedback term cannot overflow.
  localparam int PW = ACC_WIDTH + CW + 1;

  state_t                             state;
  logic [LOG_N-1:0]                   len;
  logic [LOG_N-1:0]                   cnt;
  logic [BIN_NUM-1:0][CW-1:0]         cos_all;
  logic [BIN_NUM-1:0][CW-1:0]         sin_all;
  logic [BIN_NUM-1:0][ACC_WIDTH-1:0]  q1_all;
  logic [BIN_NUM-1:0][ACC_WIDTH-1:0]  q2_all;
  logic                               clr;
  logic                               acc;

  assign o_ready = (state == ACCUM);
  assign o_busy  = (state != IDLE);
  assign clr     = (state == IDLE) && i_start;
  assign acc     = (state == ACCUM) && i_valid;

  goertzel_coef_rf #(.BIN_NUM(BIN_NUM), .CW(CW), .AW(BW)) u_coef (
    .clk     (i_sys_clk),
    .rst     (i_sys_rst),
    .we      (i_coef_we && (state == IDLE)),
    .addr    (i_coef_addr),
    .wr_cos  (i_coef_cos),
    .wr_sin  (i_coef_sin),
    .cos_all (cos_all),
    .sin_all (sin_all)
  );

  for (genvar j = 0; j < BIN_NUM; j++) begin : g_bin
    logic signed [ACC_WIDTH-1:0] q1;
    logic signed [ACC_WIDTH-1:0] q2;
    logic signed [ACC_WIDTH-1:0] fb;
    logic signed [ACC_WIDTH-1:0] q0;
    logic signed [PW-1:0]        prod;

    assign prod = PW'(q1) * PW'($signed(cos_all[j]));
    assign fb   = ACC_WIDTH'((prod <<< 1) >>> FRAC_BITS);
    assign q0   = ACC_WIDTH'($signed(i_x)) + fb - q2;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
        q1 <= '0;
        q2 <= '0;
      end else if (clr) begin
        q1 <= '0;
        q2 <= '0;
      end else if (acc) begin
        q2 <= q1;
        q1 <= q0;
      end
    end

    assign q1_all[j] = q1;
    assign q2_all[j] = q2;
  end

  // Single shared output datapath: CALC selects bin 0, DRAIN pre-selects the next bin.
  logic [BW-1:0]               sel;
  logic signed [ACC_WIDTH-1:0] q1_s;
  logic signed [ACC_WIDTH-1:0] q2_s;
  logic signed [CW-1:0]        cos_s;
  logic signed [CW-1:0]        sin_s;
  logic signed [PW-1:0]        re_w;
  logic signed [PW-1:0]        im_w;
  logic [WIDTH-1:0]            re_sat;
  logic [WIDTH-1:0]            im_sat;

  assign sel    = (state == CALC) ? '0 : BW'(o_bin + 1'b1);
  assign q1_s   = q1_all[sel];
  assign q2_s   = q2_all[sel];
  assign cos_s  = cos_all[sel];
  assign sin_s  = sin_all[sel];
  assign re_w   = PW'(q1_s) - ((PW'(q2_s) * PW'(cos_s)) >>> FRAC_BITS);
  assign im_w   = (PW'(q2_s) * PW'(sin_s)) >>> FRAC_BITS;
  assign re_sat = WIDTH'(sat_to_width(64'(re_w), WIDTH));
  assign im_sat = WIDTH'(sat_to_width(64'(im_w), WIDTH));

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state   <= IDLE;
      len     <= '0;
      cnt     <= '0;
      o_y_re  <= '0;
      o_y_im  <= '0;
      o_bin   <= '0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            len   <= LOG_N'(clamp_len(int'(i_n_len), N_MAX));
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (i_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == len - 1'b1) state <= CALC;
          end
        end
        CALC: begin
          o_y_re  <= re_sat;
          o_y_im  <= im_sat;
          o_bin   <= '0;
          o_valid <= 1'b1;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (i_ready) begin
            if (o_bin == BW'(BIN_NUM - 1)) begin
              o_valid <= 1'b0;
              o_done  <= 1'b1;
              state   <= IDLE;
            end else begin
              o_y_re <= re_sat;
              o_y_im <= im_sat;
              o_bin  <= o_bin + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_bank.sv
// Directed bench for goertzel_bank: a plain-arithmetic DFT-recurrence model per frame, checked every output cycle.
module tb_goertzel_bank;

  localparam int N_MAX     = 64;
  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 14;
  localparam int BIN_NUM   = 8;
  localparam int LOG_N     = $clog2(N_MAX) + 1;
  localparam int CW        = FRAC_BITS + 2;
  localparam int ACC_WIDTH = WIDTH + LOG_N + 2;
  localparam int BW        = $clog2(BIN_NUM);

  localparam int COS_TAB [BIN_NUM] = '{16384, 11585, 0, -11585, -16384, 15137, 6270, -6270};
  localparam int SIN_TAB [BIN_NUM] = '{0, 11585, 16384, 11585, 0, 6270, 15137, -15137};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             coef_we = 1'b0;
  logic [BW-1:0]    coef_addr = '0;
  logic [CW-1:0]    coef_cos = '0;
  logic [CW-1:0]    coef_sin = '0;
  logic             start = 1'b0;
  logic [LOG_N-1:0] n_len = '0;
  logic [WIDTH-1:0] x = '0;
  logic             valid = 1'b0;
  logic             ready;
  logic [WIDTH-1:0] y_re;
  logic [WIDTH-1:0] y_im;
  logic [BW-1:0]    bin;
  logic             y_valid;
  logic             ready_in = 1'b0;
  logic             busy;
  logic             done;

  goertzel_bank #(.N_MAX(N_MAX), .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .BIN_NUM(BIN_NUM)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_cos  (coef_cos),
    .i_coef_sin  (coef_sin),
    .i_start     (start),
    .i_n_len     (n_len),
    .i_x         (x),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_y_re      (y_re),
    .o_y_im      (y_im),
    .o_bin       (bin),
    .o_valid     (y_valid),
    .i_ready     (ready_in),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  longint samp[$];
  longint m_cos [BIN_NUM];
  longint m_sin [BIN_NUM];
  longint exp_re [BIN_NUM];
  longint exp_im [BIN_NUM];
  bit     expect_out = 1'b0;
  int     nbin = 0;
  int     done_cnt = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int clamp(input int n);
    return (n < 2) ? 2 : ((n > N_MAX) ? N_MAX : n);
  endfunction

  // floor(v / 2^FRAC_BITS)
  function automatic longint floor_frac(input longint v);
    longint d = longint'(1) << FRAC_BITS;
    longint q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap(input longint v);
    longint m = longint'(1) << ACC_WIDTH;
    longint r = v % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint sat(input longint v);
    longint hi = (longint'(1) << (WIDTH - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  task automatic model_frame(input int nl);
    int len = clamp(nl);
    for (int j = 0; j < BIN_NUM; j++) begin
      longint q1 = 0;
      longint q2 = 0;
      longint q0;
      for (int i = 0; i < len; i++) begin
        q0 = wrap(samp[i] + floor_frac(2 * m_cos[j] * q1) - q2);
        q2 = q1;
        q1 = q0;
      end
      exp_re[j] = sat(q1 - floor_frac(q2 * m_cos[j]));
      exp_im[j] = sat(floor_frac(q2 * m_sin[j]));
    end
  endtask

  task automatic fill_const(input int n, input longint v);
    samp.delete();
    for (int i = 0; i < n; i++) samp.push_back(v);
  endtask

  task automatic fill_mix(input int n, input int mul, input int md);
    samp.delete();
    for (int i = 0; i < n; i++) samp.push_back(longint'((i * mul) % md) - longint'(md / 2));
  endtask

  task automatic load_coefs();
    for (int j = 0; j < BIN_NUM; j++) begin
      @(posedge clk); #1;
      coef_we = 1'b1;
      coef_addr = BW'(j);
      coef_cos = CW'(COS_TAB[j]);
      coef_sin = CW'(SIN_TAB[j]);
      m_cos[j] = COS_TAB[j];
      m_sin[j] = SIN_TAB[j];
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_valid"}, y_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_y_re"}, y_re, 0);
    check({tag, "_y_im"}, y_im, 0);
    check({tag, "_bin"}, bin, 0);
  endtask

  // stall_bin >= BIN_NUM means no stall; inject pokes a coef write and a start mid-frame.
  task automatic run_frame(input int nl, input int stall_bin, input bit gap, input bit inject);
    int len;
    int idx;
    int guard;
    int d0;
    int st;
    int g;
    len = clamp(nl);
    model_frame(nl);
    expect_out = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    n_len = LOG_N'(nl);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_in_accum", ready, 1);
    idx = 0;
    guard = 0;
    while (idx < len && guard < 1000) begin
      valid = !(gap && (guard % 3 == 2));
      x = WIDTH'(samp[idx]);
      coef_we = inject && (idx == 3);
      start = inject && (idx == 3);
      if (inject) begin
        coef_addr = '0;
        coef_cos = CW'(1234);
        coef_sin = CW'(777);
        n_len = LOG_N'(2);
      end
      @(negedge clk);
      if (valid && ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    valid = 1'b0;
    coef_we = 1'b0;
    start = 1'b0;
    check("accum_count", idx, len);
    check("ready_drop", ready, 0);
    check("valid_in_calc", y_valid, 0);
    @(posedge clk); #1;
    check("valid_latency", y_valid, 1);
    st = 0;
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      ready_in = !(y_valid && (bin == BW'(stall_bin)) && (st < 3));
      if (!ready_in) st++;
      @(posedge clk); #1;
      g++;
    end
    ready_in = 1'b0;
    check("done_seen", done_cnt, d0 + 1);
    if (stall_bin < BIN_NUM) check("stall_cycles", st, 3);
    repeat (3) @(posedge clk);
    #1;
    check("single_done", done_cnt, d0 + 1);
    check("idle_after", busy, 0);
    expect_out = 1'b0;
  endtask

  // Every presented result is checked against the model; the bin advances only on handshake.
  always @(negedge clk) begin
    if (rst) begin
      nbin = 0;
    end else begin
      if (y_valid) begin
        if (!expect_out || nbin >= BIN_NUM) begin
          check("unexpected_valid", y_valid, 0);
        end else begin
          check("bin_idx", bin, nbin);
          check($sformatf("y_re[%0d]", nbin), $signed(y_re), exp_re[nbin]);
          check($sformatf("y_im[%0d]", nbin), $signed(y_im), exp_im[nbin]);
          if (ready_in) nbin++;
        end
      end
      if (done) begin
        check("done_after_last", nbin, BIN_NUM);
        nbin = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #3;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    load_coefs();

    // Constant input: bin 0 (DC) sums to len*x, bin 2 (quarter rate) cancels out.
    fill_const(8, 1000);
    model_frame(8);
    check("model_dc_re", exp_re[0], 8000);
    check("model_dc_im", exp_im[0], 0);
    check("model_b2_re", exp_re[2], 0);
    check("model_b2_im", exp_im[2], 0);
    run_frame(8, BIN_NUM, 1'b0, 1'b0);

    // Full-scale DC over a maximal frame saturates.
    fill_const(64, 32767);
    model_frame(64);
    check("model_sat_re", exp_re[0], 32767);
    run_frame(64, BIN_NUM, 1'b0, 1'b0);

    // Mixed data with valid gaps and a 3-cycle backpressure stall on bin 1.
    fill_mix(13, 7919, 20001);
    run_frame(13, 1, 1'b1, 1'b0);

    // Coefficient write and start during ACCUM are ignored.
    fill_const(8, 1000);
    run_frame(8, BIN_NUM, 1'b0, 1'b1);
    check("inject_model_dc", exp_re[0], 8000);

    // Length clamping at both ends.
    samp.delete();
    samp.push_back(500);
    samp.push_back(-300);
    model_frame(1);
    check("model_min_len_re", exp_re[0], 200);
    run_frame(1, BIN_NUM, 1'b0, 1'b0);
    fill_mix(64, 12345, 65535);
    run_frame(100, 5, 1'b0, 1'b0);

    // Reset mid-frame after 5 of 8 samples.
    @(posedge clk); #1;
    start = 1'b1;
    n_len = LOG_N'(8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      x = WIDTH'(1000);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("midframe_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, 6);
    for (int j = 0; j < BIN_NUM; j++) begin
      m_cos[j] = 0;
      m_sin[j] = 0;
    end
    load_coefs();
    fill_const(8, 1000);
    run_frame(8, BIN_NUM, 1'b0, 1'b0);
    check("post_rst_model_dc", exp_re[0], 8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
